// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states, line levels and parity helper.
// Used by both the transmit and receive sides of the link.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int   DATA_BITS = 8;

    // Even parity when odd=0: the returned bit makes the total count of ones even.
    function automatic logic parity_of(input logic [DATA_BITS-1:0] b, input logic odd);
        return (^b) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1 and pulses tick on the terminal count.
// restart holds the count at zero so the first bit period starts cleanly.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 5220
) (
    input  logic clk,
    input  logic clr,
    input  logic restart,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == TERM) && !restart;

    always_ff @(posedge clk) begin
        if (clr || restart) begin
            cnt <= '0;
        end else if (cnt == TERM) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmit side: accepts a byte over a four-phase req/ack handshake and
// serialises start, d0..d7 (LSB first), optional parity and stop onto txd.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5220,
    parameter bit PARITY_EN    = 1'b1,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       req,
    input  logic [7:0] data,
    output logic       ack,
    output logic       txd,
    output logic       busy
);

    uart_state_e          state;
    logic [DATA_BITS-1:0] shreg;
    logic                 par;
    logic [2:0]           bit_idx;
    logic                 armed;
    logic                 tick;
    logic                 accept;

    // A request held high through reset is stale: it must be dropped and
    // re-raised before it can start a frame, just like after a normal ack.
    assign accept = (state == IDLE) && req && !ack && armed;
    assign busy   = (state != IDLE);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .clr    (clr),
        .restart(state == IDLE),
        .tick   (tick)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state   <= IDLE;
            txd     <= STOP_BIT;
            ack     <= 1'b0;
            bit_idx <= '0;
            armed   <= !req;
        end else begin
            if (accept) begin
                ack <= 1'b1;
            end else if (ack && !req) begin
                ack <= 1'b0;
            end

            if (!req) begin
                armed <= 1'b1;
            end else if (accept) begin
                armed <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        shreg <= data;
                        par   <= parity_of(data, PARITY_ODD);
                        txd   <= START_BIT;
                        state <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        txd     <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_idx <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_idx == 3'(DATA_BITS - 1)) begin
                            if (PARITY_EN) begin
                                txd   <= par;
                                state <= PARITY;
                            end else begin
                                txd   <= STOP_BIT;
                                state <= STOP;
                            end
                        end else begin
                            txd     <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        txd   <= STOP_BIT;
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (tick) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: three instances (even parity, odd parity, no parity)
// with a frame scoreboard per instance fed by a bit-list reference model.
module tb_uart_transmitter;

    localparam int N  = 4;
    localparam int NI = 3;

    typedef struct packed {
        logic [10:0] bits;
        logic [3:0]  len;
    } frame_t;

    logic       clk = 1'b0;
    logic       clr;
    logic       clr_prev;
    logic       req  [NI];
    logic [7:0] data [NI];
    logic       ack  [NI];
    logic       txd  [NI];
    logic       busy [NI];

    int vectors     = 0;
    int miscompares = 0;

    frame_t q0[$];
    frame_t q1[$];
    frame_t q2[$];

    always #5 clk = ~clk;

    uart_transmitter #(.CLKS_PER_BIT(N), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u0 (
        .clk(clk), .clr(clr), .req(req[0]), .data(data[0]),
        .ack(ack[0]), .txd(txd[0]), .busy(busy[0]));
    uart_transmitter #(.CLKS_PER_BIT(N), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u1 (
        .clk(clk), .clr(clr), .req(req[1]), .data(data[1]),
        .ack(ack[1]), .txd(txd[1]), .busy(busy[1]));
    uart_transmitter #(.CLKS_PER_BIT(N), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u2 (
        .clk(clk), .clr(clr), .req(req[2]), .data(data[2]),
        .ack(ack[2]), .txd(txd[2]), .busy(busy[2]));

    // Reference frame: list of line levels, one entry per bit period.
    function automatic frame_t build_frame(input int k, input logic [7:0] b);
        frame_t f;
        int ones;
        ones   = 0;
        f.bits = '0;
        f.bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f.bits[1+i] = b[i];
            if (b[i]) ones++;
        end
        if (k == 2) begin
            f.bits[9] = 1'b1;
            f.len     = 4'd10;
        end else begin
            f.bits[9]  = (((ones + ((k == 1) ? 1 : 0)) % 2) == 1);
            f.bits[10] = 1'b1;
            f.len      = 4'd11;
        end
        return f;
    endfunction

    function automatic void push_exp(input int k, input logic [7:0] b);
        case (k)
            0:       q0.push_back(build_frame(k, b));
            1:       q1.push_back(build_frame(k, b));
            default: q2.push_back(build_frame(k, b));
        endcase
    endfunction

    function automatic int qsize(input int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic frame_t pop_exp(input int k);
        case (k)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    task automatic chk(input string name, input int k, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s u%0d: got %b expected %b at %0t", name, k, act, exp, $time);
        end
    endtask

    // Monitor: entered on the first negedge where busy is seen.
    task automatic run_frame(input int k);
        frame_t f;
        int total;
        if (qsize(k) == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_frame u%0d: got busy=1 expected no frame at %0t", k, $time);
            for (int n = 0; n < 20 * N && busy[k] === 1'b1; n++) @(negedge clk);
            return;
        end
        f = pop_exp(k);
        total = int'(f.len) * N;
        for (int c = 0; c < total; c++) begin
            if (c > 0) @(negedge clk);
            chk("txd_bit", k, txd[k], f.bits[c / N]);
            chk("busy_frame", k, busy[k], 1'b1);
            if (clr) return;
        end
        @(negedge clk);
        chk("busy_end", k, busy[k], 1'b0);
        chk("idle_high", k, txd[k], 1'b1);
    endtask

    task automatic monitor(input int k);
        forever begin
            @(negedge clk);
            if (busy[k] === 1'b1) run_frame(k);
        end
    endtask

    initial begin
        for (int k = 0; k < NI; k++) begin
            fork
                automatic int kk = k;
                monitor(kk);
            join_none
        end
    end

    // Any edge that sampled clr=1 must leave every instance idle.
    initial begin
        clr_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (clr_prev) begin
                for (int k = 0; k < NI; k++) begin
                    chk("rst_txd", k, txd[k], 1'b1);
                    chk("rst_ack", k, ack[k], 1'b0);
                    chk("rst_busy", k, busy[k], 1'b0);
                end
            end
            clr_prev = clr;
        end
    end

    // Send to an idle, armed instance; ack must rise exactly one edge after req.
    task automatic send(input int k, input logic [7:0] b, input int hold);
        @(posedge clk);
        #1;
        push_exp(k, b);
        data[k] = b;
        req[k]  = 1'b1;
        @(negedge clk);
        chk("ack_pre", k, ack[k], 1'b0);
        @(negedge clk);
        chk("ack_rise", k, ack[k], 1'b1);
        chk("busy_rise", k, busy[k], 1'b1);
        repeat (hold) @(negedge clk);
        chk("ack_hold", k, ack[k], 1'b1);
        @(posedge clk);
        #1;
        req[k]  = 1'b0;
        data[k] = 8'($urandom);
        @(negedge clk);
        @(negedge clk);
        chk("ack_fall", k, ack[k], 1'b0);
    endtask

    // Send whenever the instance is ready to accept; producer re-requests freely.
    task automatic send_wait(input int k, input logic [7:0] b);
        @(posedge clk);
        #1;
        push_exp(k, b);
        data[k] = b;
        req[k]  = 1'b1;
        for (int n = 0; n < 30 * N && ack[k] !== 1'b1; n++) @(negedge clk);
        chk("ack_wait", k, ack[k], 1'b1);
        @(posedge clk);
        #1;
        req[k]  = 1'b0;
        data[k] = 8'($urandom);
        for (int n = 0; n < 10 && ack[k] !== 1'b0; n++) @(negedge clk);
        chk("ack_release", k, ack[k], 1'b0);
    endtask

    task automatic wait_idle(input int k);
        for (int n = 0; n < 30 * N && busy[k] !== 1'b0; n++) @(negedge clk);
        chk("idle_reached", k, busy[k], 1'b0);
        repeat (2) @(negedge clk);
    endtask

    task automatic rand_run(input int k);
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 5)) @(posedge clk);
            send_wait(k, 8'($urandom));
        end
        wait_idle(k);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish within 20000 cycles");
        $fatal(1, "timeout");
    end

    initial begin
        clr = 1'b1;
        for (int k = 0; k < NI; k++) begin
            req[k]  = 1'b0;
            data[k] = 8'h00;
        end
        // Reset held three cycles with a pending request; it must stay stale.
        req[0]  = 1'b1;
        data[0] = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        clr = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("stale_req_busy", 0, busy[0], 1'b0);
            chk("stale_req_ack", 0, ack[0], 1'b0);
        end
        @(posedge clk);
        #1;
        req[0] = 1'b0;

        send(0, 8'hA5, 2);
        wait_idle(0);

        // Long hold: exactly one frame, then an immediate re-request.
        send(0, 8'($urandom), 100);
        send(0, 8'($urandom), 3);
        wait_idle(0);

        // Reset in the middle of d3, then a clean frame.
        send(0, 8'($urandom), 1);
        repeat (13) @(negedge clk);
        @(posedge clk);
        #1;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        repeat (2) @(negedge clk);
        send(0, 8'h3C, 2);
        wait_idle(0);

        send_wait(1, 8'h00);
        send_wait(1, 8'hFF);
        wait_idle(1);

        send(2, 8'h81, 2);
        wait_idle(2);

        fork
            rand_run(0);
            rand_run(1);
            rand_run(2);
        join

        for (int k = 0; k < NI; k++) begin
            chk("queue_drained", k, qsize(k) == 0, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
